lcb_responder: RTL and testbench
================================

# lcb_responder

Slave-side endpoint of the LCB polling link: decodes request frames arriving on an RS-485 receive byte stream and answers each valid one with a fixed-length response frame through a byte-level UART transmitter. Used as the LCB emulator in bench/loop-back builds and as the firmware core of the LCB board itself. Sits between a UARTRX-style receiver, a byte UART transmitter and a 2-cycle-latency sample memory (ROM/RAM).

## Interface
- REQ_BYTES, 14: request frame length, header and checksum included (4..31)
- RSP_BYTES, 16: response frame length, header and checksum included (4..19)
- REQ_HDR, 8'h5A: request header byte
- RSP_HDR, 8'hA5: response header byte
- TIMEOUT, 800: max clk cycles between accepted request bytes
- TURNAROUND, 160: clk cycles from request accept to line turnaround

- clk  in  1  single clock (80 MHz in TheFFM)
- reset  in  1  asynchronous, active-low
- rx_data  in  8  received byte, valid while rx_valid high
- rx_valid  in  1  level; a byte is taken on its rising edge only
- tx_data  out  8  byte to transmit, stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle pulse, issued only while tx_busy low
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start
- dir_tx  out  1  RS-485 driver enable
- dir_rx  out  1  RS-485 receiver enable, always ~dir_tx
- mem_addr  out  9  sample memory address
- mem_data  in  8  sample memory data, 2 cycles after mem_addr
- req_num  out  5  request number of last valid frame
- req_ok  out  1  one-cycle pulse, valid frame accepted
- req_err  out  1  one-cycle pulse, checksum fail or timeout

## Operation
- Request frame: byte0 = REQ_HDR, byte1[4:0] = request number (bits 7:5 ignored), bytes 2..REQ_BYTES-2 payload (ignored), last byte = sum mod 256 of all preceding bytes.
- Response frame: byte0 = RSP_HDR, byte1 = {3'b000, req_num}, bytes 2..RSP_BYTES-2 = mem_data at mem_addr = {req_num, 4'b0} + k, k = 0..RSP_BYTES-4, last byte = sum mod 256 of all preceding response bytes.
- States: IDLE, RECV, CHECK, TURN, FETCH, SEND, WAITB.
- IDLE: on byte == REQ_HDR -> RECV, checksum = REQ_HDR, index = 1; other bytes ignored.
- RECV: each byte adds to checksum, index++; byte1 captured to a shadow register; after last byte -> CHECK. Gap counter reset on every byte; reaching TIMEOUT -> req_err, IDLE.
- CHECK (1 cycle): sum match -> req_num updated, req_ok, TURN; mismatch -> req_err, IDLE, req_num unchanged.
- TURN: dir_tx = 1, count TURNAROUND cycles -> FETCH.
- FETCH: header/number/checksum bytes need no memory; data bytes drive mem_addr and wait 2 cycles, latch mem_data -> SEND.
- SEND: when tx_busy low, tx_data loaded and tx_start pulsed -> WAITB.
- WAITB: wait for tx_busy fall; more bytes -> FETCH, else dir_tx = 0 -> IDLE.
- Receive bytes arriving outside IDLE/RECV are discarded (no edge pending after return to IDLE).

## Timing
- Reset values: tx_data 0, tx_start 0, dir_tx 0, dir_rx 1, mem_addr 0, req_num 0, req_ok 0, req_err 0; state IDLE, counters and checksum 0.
- Rising edge of rx_valid at cycle T is accepted at T (registered edge detect, 1-cycle detect delay allowed if uniform).
- Last request byte accepted at T: CHECK/req_ok at T+1, dir_tx high from T+2, first tx_start at T+2+TURNAROUND (tx_busy low).
- Data byte: mem_addr set at cycle F, mem_data latched at F+2, tx_start at F+3 earliest.
- dir_tx falls the cycle after tx_busy falls for the last byte; dir_rx rises same cycle.
- Reset asserted mid-frame or mid-response: all outputs return to reset values immediately; a transmitter byte in flight is not cancelled by this block.
- rx_valid held high across a state change yields no second acceptance.

## Test plan
- Valid request 5A 03 00..00 (11 zeros) 5D with memory = address[7:0] -> req_ok at T+1, req_num = 3, first tx_start at T+162, response A5 03 30 31 .. 3C then checksum (sum mod 256), 16 bytes total, dir_tx high throughout.
- Same frame with last byte 5E -> req_err pulse, no tx_start, dir_tx stays 0, req_num keeps previous value.
- Header then 801-cycle gap -> req_err, IDLE; following complete valid frame accepted normally.
- Leading garbage bytes 00 FF 12 before valid frame -> ignored, frame answered once.
- New request bytes injected while responding -> ignored; only one response, no req_ok.
- reset low during 7th response byte -> dir_tx 0, tx_start 0 next cycle; after release a fresh request is answered correctly.

Source files
------------

// File: rtl/lcb_responder_if.sv
// -----------------------------------------------------------------------------
// lcb_responder_if
//
// Groups the byte-stream, transmitter, sample-memory and status signals of the
// LCB responder. Clock and reset stay plain ports on the modules.
//
// Handshakes:
//   rx_valid/rx_data : rx_valid is a level; a byte is taken only on its rising
//                      edge, rx_data valid while rx_valid is high. No ready
//                      path back to the receiver: bytes the responder does not
//                      want are simply dropped.
//   tx_start/tx_busy : tx_start is a one-cycle pulse, issued only while tx_busy
//                      is low; tx_data is held from tx_start until tx_busy
//                      falls. tx_busy rises the cycle after tx_start.
//   mem_addr/mem_data: mem_data reflects mem_addr two cycles later.
//
// Modports:
//   slave  - responder side (drives tx_*, dir_*, mem_addr, req_*)
//   master - environment side (drives rx_*, tx_busy, mem_data)
// -----------------------------------------------------------------------------
interface lcb_responder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       dir_tx;
    logic       dir_rx;
    logic [8:0] mem_addr;
    logic [7:0] mem_data;
    logic [4:0] req_num;
    logic       req_ok;
    logic       req_err;

    modport slave (
        input  rx_data, rx_valid, tx_busy, mem_data,
        output tx_data, tx_start, dir_tx, dir_rx, mem_addr, req_num, req_ok, req_err
    );

    modport master (
        output rx_data, rx_valid, tx_busy, mem_data,
        input  tx_data, tx_start, dir_tx, dir_rx, mem_addr, req_num, req_ok, req_err
    );
endinterface

// File: rtl/lcb_responder.sv
// -----------------------------------------------------------------------------
// lcb_responder
//
// Slave endpoint of the LCB polling link. Decodes request frames from the
// RS-485 receive byte stream and answers every valid one with a fixed-length
// response frame built from sample memory, sent byte by byte through a UART
// transmitter.
//
// Request : REQ_HDR, number (bits 4:0), payload..., sum of preceding bytes
// Response: RSP_HDR, {3'b0, number}, mem[{number,4'b0}+k]..., sum of preceding
//
// Ports:
//   clk_i       - single clock
//   rst_ni      - asynchronous active-low reset
//   bus         - lcb_responder_if.slave (rx stream, tx byte UART, RS-485
//                 direction, sample memory, request status)
//   dbg_state_o - current FSM state encoding
// -----------------------------------------------------------------------------
module lcb_responder #(
    parameter int         REQ_BYTES  = 14,
    parameter int         RSP_BYTES  = 16,
    parameter logic [7:0] REQ_HDR    = 8'h5A,
    parameter logic [7:0] RSP_HDR    = 8'hA5,
    parameter int         TIMEOUT    = 800,
    parameter int         TURNAROUND = 160
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    lcb_responder_if.slave         bus,
    output logic [2:0]             dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_CHECK = 3'd2,
        S_TURN  = 3'd3,
        S_FETCH = 3'd4,
        S_SEND  = 3'd5,
        S_WAITB = 3'd6
    } state_e;

    localparam int GAP_W  = $clog2(TIMEOUT + 1);
    localparam int TURN_W = $clog2(TURNAROUND + 1);

    localparam logic [4:0]        REQ_LAST = 5'(REQ_BYTES - 1);
    localparam logic [4:0]        RSP_LAST = 5'(RSP_BYTES - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT - 1);
    // The header byte's FETCH and SEND cycles finish the turnaround, so the
    // first tx_start lands exactly TURNAROUND cycles after dir_tx rises.
    localparam logic [TURN_W-1:0] TURN_END = TURN_W'(TURNAROUND - 3);

    state_e              state_q, state_d;
    logic                rx_valid_q;
    logic                tx_busy_q;
    logic [4:0]          idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [4:0]          num_sh_q, num_sh_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic [4:0]          byte_q, byte_d;
    logic [1:0]          wait_q, wait_d;
    logic [7:0]          stage_q, stage_d;
    logic [7:0]          rsp_sum_q, rsp_sum_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                dir_tx_q, dir_tx_d;
    logic [8:0]          mem_addr_q, mem_addr_d;
    logic [4:0]          req_num_q, req_num_d;
    logic                req_ok_q, req_ok_d;
    logic                req_err_q, req_err_d;

    logic                rx_edge;
    logic                busy_fall;
    logic [4:0]          byte_nxt;
    logic [8:0]          addr_nxt;

    // Rising-edge detect: a level held across a state change is never taken
    // twice, and edges seen outside IDLE/RECV leave nothing pending.
    assign rx_edge   = bus.rx_valid & ~rx_valid_q;
    assign busy_fall = tx_busy_q & ~bus.tx_busy;

    assign byte_nxt  = byte_q + 5'd1;
    assign addr_nxt  = {req_num_q, 4'b0000} + {4'b0000, byte_nxt - 5'd2};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rx_valid_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            idx_q      <= '0;
            csum_q     <= '0;
            num_sh_q   <= '0;
            gap_q      <= '0;
            turn_q     <= '0;
            byte_q     <= '0;
            wait_q     <= '0;
            stage_q    <= '0;
            rsp_sum_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            dir_tx_q   <= 1'b0;
            mem_addr_q <= '0;
            req_num_q  <= '0;
            req_ok_q   <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= bus.rx_valid;
            tx_busy_q  <= bus.tx_busy;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            num_sh_q   <= num_sh_d;
            gap_q      <= gap_d;
            turn_q     <= turn_d;
            byte_q     <= byte_d;
            wait_q     <= wait_d;
            stage_q    <= stage_d;
            rsp_sum_q  <= rsp_sum_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            dir_tx_q   <= dir_tx_d;
            mem_addr_q <= mem_addr_d;
            req_num_q  <= req_num_d;
            req_ok_q   <= req_ok_d;
            req_err_q  <= req_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        num_sh_d   = num_sh_q;
        gap_d      = gap_q;
        turn_d     = turn_q;
        byte_d     = byte_q;
        wait_d     = wait_q;
        stage_d    = stage_q;
        rsp_sum_d  = rsp_sum_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        dir_tx_d   = dir_tx_q;
        mem_addr_d = mem_addr_q;
        req_num_d  = req_num_q;
        req_ok_d   = 1'b0;
        req_err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_edge && bus.rx_data == REQ_HDR) begin
                    state_d = S_RECV;
                    csum_d  = REQ_HDR;
                    idx_d   = 5'd1;
                    gap_d   = '0;
                end
            end

            S_RECV: begin
                if (rx_edge) begin
                    gap_d = '0;
                    if (idx_q == 5'd1) begin
                        num_sh_d = bus.rx_data[4:0];
                    end
                    if (idx_q == REQ_LAST) begin
                        // The verdict is registered with the last byte so
                        // req_ok/req_err and req_num are visible during CHECK.
                        state_d = S_CHECK;
                        if (csum_q == bus.rx_data) begin
                            req_ok_d  = 1'b1;
                            req_num_d = num_sh_q;
                        end else begin
                            req_err_d = 1'b1;
                        end
                    end else begin
                        csum_d = csum_q + bus.rx_data;
                        idx_d  = idx_q + 5'd1;
                    end
                end else if (gap_q == GAP_MAX) begin
                    req_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            S_CHECK: begin
                // req_ok_q carries the checksum verdict for this one cycle.
                if (req_ok_q) begin
                    state_d   = S_TURN;
                    dir_tx_d  = 1'b1;
                    turn_d    = '0;
                    byte_d    = '0;
                    rsp_sum_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_TURN: begin
                if (turn_q == TURN_END) begin
                    state_d = S_FETCH;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end

            S_FETCH: begin
                if (byte_q == 5'd0) begin
                    stage_d = RSP_HDR;
                    state_d = S_SEND;
                end else if (byte_q == 5'd1) begin
                    stage_d = {3'b000, req_num_q};
                    state_d = S_SEND;
                end else if (byte_q == RSP_LAST) begin
                    stage_d = rsp_sum_q;
                    state_d = S_SEND;
                end else if (wait_q == 2'd2) begin
                    // mem_addr was issued on entry to FETCH; data valid now.
                    stage_d = bus.mem_data;
                    state_d = S_SEND;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end

            S_SEND: begin
                if (!bus.tx_busy) begin
                    tx_data_d  = stage_q;
                    tx_start_d = 1'b1;
                    rsp_sum_d  = rsp_sum_q + stage_q;
                    state_d    = S_WAITB;
                end
            end

            S_WAITB: begin
                if (busy_fall) begin
                    if (byte_q == RSP_LAST) begin
                        dir_tx_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        byte_d  = byte_nxt;
                        wait_d  = '0;
                        state_d = S_FETCH;
                        // Issue the address now so FETCH only waits for data.
                        if (byte_nxt >= 5'd2 && byte_nxt < RSP_LAST) begin
                            mem_addr_d = addr_nxt;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.dir_tx   = dir_tx_q;
    assign bus.dir_rx   = ~dir_tx_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.req_num  = req_num_q;
    assign bus.req_ok   = req_ok_q;
    assign bus.req_err  = req_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lcb_responder.sv
// -----------------------------------------------------------------------------
// tb_lcb_responder
//
// Directed bench for lcb_responder: receiver driver, byte-UART transmitter
// model, 2-cycle sample memory (data = address[7:0]) and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_lcb_responder;
  localparam int RSP_BYTES   = 16;
  localparam int TX_BUSY_CYC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  lcb_responder_if bus_if();

  lcb_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // sample memory: data appears two cycles after the address
  logic [8:0] mem_p1;
  always @(posedge clk) begin
    mem_p1 <= bus_if.mem_addr;
    bus_if.mem_data <= mem_p1[7:0];
  end

  // transmitter: busy from the cycle after tx_start; not affected by reset
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (bus_if.tx_start) busy_cnt <= TX_BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus_if.tx_busy = (busy_cnt != 0);

  // scoreboard
  logic [7:0] exp_q[$];
  int ok_cnt = 0, err_cnt = 0, tx_cnt = 0;
  int ok_cyc = 0, err_cyc = 0, first_tx_cyc = 0, busy_fall_cyc = 0;
  logic resp_first = 1'b0;
  logic dir_prev = 1'b0, busy_prev = 1'b0, rst_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.req_ok) begin ok_cnt++; ok_cyc = cyc; end
      if (bus_if.req_err) begin err_cnt++; err_cyc = cyc; end
      if (bus_if.tx_start) begin
        if (resp_first) begin first_tx_cyc = cyc; resp_first = 1'b0; end
        tx_cnt++;
        check("tx_dir_tx", bus_if.dir_tx, 1);
        check("tx_dir_rx", bus_if.dir_rx, 0);
        check("tx_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", bus_if.tx_data, exp_q.pop_front());
      end
      if (busy_prev && !bus_if.tx_busy) busy_fall_cyc = cyc;
      if (rst_prev && dir_prev && !bus_if.dir_tx) check("dir_fall_cyc", cyc, busy_fall_cyc + 1);
    end
    dir_prev  = bus_if.dir_tx;
    busy_prev = bus_if.tx_busy;
    rst_prev  = rst_n;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, output int t_acc);
    @(posedge clk); #1;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    t_acc = cyc;
    repeat (2) @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
  endtask

  // 14-byte request; payload byte i = fill*i, optional checksum corruption
  task automatic send_frame(input logic [7:0] b1, input logic [7:0] fill,
                            input logic corrupt, output int t_last);
    logic [7:0] sum;
    logic [7:0] b;
    int t;
    send_byte(8'h5A, t);
    sum = 8'h5A;
    send_byte(b1, t);
    sum = sum + b1;
    for (int i = 2; i < 13; i++) begin
      b = 8'(int'(fill) * i);
      send_byte(b, t);
      sum = sum + b;
    end
    send_byte(sum + {7'd0, corrupt}, t_last);
  endtask

  task automatic push_rsp(input logic [4:0] num);
    logic [7:0] s;
    logic [8:0] a;
    s = 8'hA5 + {3'b000, num};
    exp_q.push_back(8'hA5);
    exp_q.push_back({3'b000, num});
    for (int k = 0; k < RSP_BYTES - 3; k++) begin
      a = {num, 4'b0000} + 9'(k);
      exp_q.push_back(a[7:0]);
      s = s + a[7:0];
    end
    exp_q.push_back(s);
  endtask

  task automatic wait_rsp_done(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && bus_if.dir_tx == 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 3000, 1);
    repeat (5) @(negedge clk);
  endtask

  int t, h, ok0, err0, tx0, n;

  initial begin
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", bus_if.tx_data, 0);
    check("rst_tx_start", bus_if.tx_start, 0);
    check("rst_dir_tx", bus_if.dir_tx, 0);
    check("rst_dir_rx", bus_if.dir_rx, 1);
    check("rst_mem_addr", bus_if.mem_addr, 0);
    check("rst_req_num", bus_if.req_num, 0);
    check("rst_req_ok", bus_if.req_ok, 0);
    check("rst_req_err", bus_if.req_err, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: valid request number 3, hand-computed response
    exp_q = '{8'hA5, 8'h03, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
              8'h37, 8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h66};
    ok0 = ok_cnt; tx0 = tx_cnt; resp_first = 1'b1;
    send_frame(8'h03, 8'h00, 1'b0, t);
    @(negedge clk);
    check("t1_ok_cyc", ok_cyc, t + 1);
    check("t1_ok_cnt", ok_cnt - ok0, 1);
    check("t1_req_num", bus_if.req_num, 3);
    check("t1_dir_tx_t2", bus_if.dir_tx, 1);
    check("t1_dir_rx_t2", bus_if.dir_rx, 0);
    wait_rsp_done("t1_rsp_done");
    check("t1_first_tx", first_tx_cyc, t + 162);
    check("t1_tx_cnt", tx_cnt - tx0, 16);
    check("t1_dir_rx_end", bus_if.dir_rx, 1);

    // 2: bad checksum, different number -> error, no response, req_num kept
    ok0 = ok_cnt; err0 = err_cnt; tx0 = tx_cnt;
    send_frame(8'h0B, 8'h00, 1'b1, t);
    repeat (300) @(negedge clk);
    check("t2_err_cyc", err_cyc, t + 1);
    check("t2_err_cnt", err_cnt - err0, 1);
    check("t2_ok_cnt", ok_cnt - ok0, 0);
    check("t2_tx_cnt", tx_cnt - tx0, 0);
    check("t2_dir_tx", bus_if.dir_tx, 0);
    check("t2_req_num", bus_if.req_num, 3);

    // 3: header then silence -> timeout error; then a frame (bits 7:5 set)
    err0 = err_cnt;
    send_byte(8'h5A, h);
    while (cyc < h + 790) @(negedge clk);
    check("t3_no_early_err", err_cnt - err0, 0);
    while (cyc < h + 810) @(negedge clk);
    check("t3_timeout_err", err_cnt - err0, 1);
    check("t3_state_idle", dbg_state, 0);
    push_rsp(5'd5);
    ok0 = ok_cnt; tx0 = tx_cnt; resp_first = 1'b1;
    send_frame(8'hE5, 8'h11, 1'b0, t);
    wait_rsp_done("t3_rsp_done");
    check("t3_ok_cnt", ok_cnt - ok0, 1);
    check("t3_req_num", bus_if.req_num, 5);
    check("t3_first_tx", first_tx_cyc, t + 162);
    check("t3_tx_cnt", tx_cnt - tx0, 16);

    // 4: leading garbage ignored
    push_rsp(5'd9);
    ok0 = ok_cnt; tx0 = tx_cnt; resp_first = 1'b1;
    send_byte(8'h00, h);
    send_byte(8'hFF, h);
    send_byte(8'h12, h);
    send_frame(8'h09, 8'h03, 1'b0, t);
    wait_rsp_done("t4_rsp_done");
    check("t4_ok_cnt", ok_cnt - ok0, 1);
    check("t4_tx_cnt", tx_cnt - tx0, 16);
    check("t4_req_num", bus_if.req_num, 9);

    // 5: a second request injected while responding is ignored
    push_rsp(5'd7);
    ok0 = ok_cnt; tx0 = tx_cnt; resp_first = 1'b1;
    send_frame(8'h07, 8'h00, 1'b0, t);
    n = 0;
    while (tx_cnt == tx0 && n < 1000) begin @(negedge clk); n++; end
    check("t5_rsp_started", n < 1000, 1);
    send_frame(8'h02, 8'h00, 1'b0, h);
    wait_rsp_done("t5_rsp_done");
    check("t5_ok_cnt", ok_cnt - ok0, 1);
    check("t5_tx_cnt", tx_cnt - tx0, 16);
    check("t5_req_num", bus_if.req_num, 7);

    // 6: reset during the 7th response byte, then a fresh request
    push_rsp(5'd1);
    tx0 = tx_cnt; resp_first = 1'b1;
    send_frame(8'h01, 8'h00, 1'b0, t);
    n = 0;
    while (tx_cnt - tx0 < 7 && n < 2000) begin @(negedge clk); n++; end
    check("t6_reached_7th", n < 2000, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_dir_tx", bus_if.dir_tx, 0);
    check("t6_rst_dir_rx", bus_if.dir_rx, 1);
    check("t6_rst_tx_start", bus_if.tx_start, 0);
    check("t6_rst_req_num", bus_if.req_num, 0);
    check("t6_rst_mem_addr", bus_if.mem_addr, 0);
    check("t6_rst_state", dbg_state, 0);
    exp_q.delete();
    resp_first = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    push_rsp(5'd4);
    ok0 = ok_cnt; tx0 = tx_cnt; resp_first = 1'b1;
    send_frame(8'h04, 8'h05, 1'b0, t);
    wait_rsp_done("t6_rsp_done");
    check("t6_ok_cnt", ok_cnt - ok0, 1);
    check("t6_req_num", bus_if.req_num, 4);
    check("t6_first_tx", first_tx_cyc, t + 162);
    check("t6_tx_cnt", tx_cnt - tx0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
